riscv_branch_predictor: RTL

//  Parametrised dynamic branch predictor and control-hazard resolver for the pipelined RISC-V core.

---
 rtl/riscv_branch_predictor.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/riscv_branch_predictor.sv
// Direct-mapped 2-bit-counter branch predictor: 0-cycle F-stage lookup and same-cycle E-stage flush/redirect.
// No backpressure. Table updates land on the next edge. Define BPRED_STATS_EN to build the branch/mispredict counters.
module riscv_branch_predictor #(
    parameter int          ENTRIES  = 16,
    parameter int          TAG_W    = 8,
    parameter logic [1:0]  CNT_INIT = 2'b01
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] f_pc_i,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    input  logic        e_valid_i,
    input  logic [31:0] e_pc_i,
    input  logic        e_taken_i,
    input  logic [31:0] e_target_i,
    input  logic        e_pred_taken_i,
    input  logic [31:0] e_pred_target_i,
    output logic        flush_o,
    output logic [31:0] redirect_pc_o,
    output logic [31:0] br_cnt_o,
    output logic [31:0] mispred_cnt_o
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic              valid_q [ENTRIES];
    logic [1:0]        cnt_q   [ENTRIES];
    logic [TAG_W-1:0]  tag_q   [ENTRIES];
    logic [31:0]       tgt_q   [ENTRIES];

    logic [IDX_W-1:0]  f_idx;
    logic [TAG_W-1:0]  f_tag;
    logic              f_hit;
    logic [31:0]       f_pc_inc;

    logic [IDX_W-1:0]  e_idx;
    logic [TAG_W-1:0]  e_tag;
    logic              e_hit;
    logic              mis;

    logic              wr_en;
    logic              valid_d;
    logic [1:0]        cnt_d;
    logic [TAG_W-1:0]  tag_d;
    logic [31:0]       tgt_d;

    // Fetch-side lookup reads the registered table, so a same-cycle update is not visible yet.
    always_comb begin
        f_idx         = f_pc_i[IDX_W+1:2];
        f_tag         = f_pc_i[IDX_W+TAG_W+1:IDX_W+2];
        f_pc_inc      = f_pc_i + 32'd4;
        f_hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        pred_taken_o  = !rst_i && f_hit && cnt_q[f_idx][1];
        pred_target_o = pred_taken_o ? tgt_q[f_idx] : f_pc_inc;
    end

    always_comb begin
        mis = e_valid_i && ((e_taken_i != e_pred_taken_i) ||
                            (e_taken_i && (e_target_i != e_pred_target_i)));
        flush_o       = mis && !rst_i;
        redirect_pc_o = e_taken_i ? e_target_i : (e_pc_i + 32'd4);
    end

    always_comb begin
        e_idx   = e_pc_i[IDX_W+1:2];
        e_tag   = e_pc_i[IDX_W+TAG_W+1:IDX_W+2];
        e_hit   = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
        wr_en   = 1'b0;
        valid_d = valid_q[e_idx];
        cnt_d   = cnt_q[e_idx];
        tag_d   = tag_q[e_idx];
        tgt_d   = tgt_q[e_idx];
        if (e_valid_i && !rst_i) begin
            if (e_hit) begin
                wr_en = 1'b1;
                if (e_taken_i) begin
                    cnt_d = (cnt_q[e_idx] == 2'b11) ? 2'b11 : cnt_q[e_idx] + 2'b01;
                    tgt_d = e_target_i;
                end else begin
                    cnt_d = (cnt_q[e_idx] == 2'b00) ? 2'b00 : cnt_q[e_idx] - 2'b01;
                end
            end else if (e_taken_i) begin
                // Taken miss evicts whatever occupies the slot, starting it weakly taken.
                wr_en   = 1'b1;
                valid_d = 1'b1;
                cnt_d   = 2'b10;
                tag_d   = e_tag;
                tgt_d   = e_target_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= CNT_INIT;
            end
        end else if (wr_en) begin
            valid_q[e_idx] <= valid_d;
            cnt_q[e_idx]   <= cnt_d;
        end
    end

    // Tags and targets are qualified by valid, so they need no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            tag_q[e_idx] <= tag_d;
            tgt_q[e_idx] <= tgt_d;
        end
    end

`ifdef BPRED_STATS_EN
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    always_comb begin
        br_cnt_d      = br_cnt_q + (e_valid_i ? 32'd1 : 32'd0);
        mispred_cnt_d = mispred_cnt_q + (mis ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            br_cnt_q      <= 32'd0;
            mispred_cnt_q <= 32'd0;
        end else begin
            br_cnt_q      <= br_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign br_cnt_o      = br_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;
`else
    assign br_cnt_o      = 32'd0;
    assign mispred_cnt_o = 32'd0;
`endif

endmodule
